// File: rtl/fan_pkg.sv
// Shared types, constants and helper functions for the fan speed controller.
package fan_pkg;

    // Width of the level and timer-remaining fields seen by the display side
    localparam int LEVEL_W = 4;
    localparam int TIMER_W = 16;

    // Off-timer selections, advanced in order by the timer button
    typedef enum logic [1:0] {
        T_OFF = 2'd0,
        T_X1  = 2'd1,
        T_X2  = 2'd2,
        T_X4  = 2'd3
    } timer_sel_e;

    // Ceiling log2, used to size the divider and period counters
    function automatic int unsigned fan_clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    // Target duty for a level: floor(level * full_scale / levels)
    function automatic int unsigned level_to_duty(input int unsigned lvl,
                                                  input int unsigned n,
                                                  input int unsigned levels);
        int unsigned full_scale;
        full_scale = (32'd1 << n) - 32'd1;
        return (lvl * full_scale) / levels;
    endfunction

    // Multiplier of the timer unit for each selection
    function automatic int unsigned timer_mult(input timer_sel_e sel);
        case (sel)
            T_X1:    return 1;
            T_X2:    return 2;
            T_X4:    return 4;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/fan_speed_ramp_ctrl_if.sv
// Button inputs and display/driver outputs of the fan controller.
interface fan_speed_ramp_ctrl_if
    import fan_pkg::*;
#(
    parameter int N = 12
);

    logic               fan_en;
    logic               btn_up_p;
    logic               btn_down_p;
    logic               btn_timer_p;
    logic [LEVEL_W-1:0] level;
    logic [N-1:0]       duty_now;
    logic               ramping;
    timer_sel_e         timer_sel;
    logic [TIMER_W-1:0] timer_remain;
    logic               pwm;

    // Front-end side: drives buttons, observes status
    modport master (
        output fan_en, btn_up_p, btn_down_p, btn_timer_p,
        input  level, duty_now, ramping, timer_sel, timer_remain, pwm
    );

    // Controller side
    modport slave (
        input  fan_en, btn_up_p, btn_down_p, btn_timer_p,
        output level, duty_now, ramping, timer_sel, timer_remain, pwm
    );

endinterface

// File: rtl/fan_pwm_gen.sv
// Glitch-free PWM: the compare value only changes as a new period starts.
module fan_pwm_gen
    import fan_pkg::*;
#(
    parameter int SYS_FREQ = 125,
    parameter int N        = 12,
    parameter int PWM_FREQ = 200
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] duty,
    output logic         pwm
);

    localparam int unsigned PERIOD = (SYS_FREQ * 1_000_000) / PWM_FREQ;
    localparam int CNT_W  = (fan_clog2(PERIOD) < 1) ? 1 : fan_clog2(PERIOD);
    localparam int PROD_W = N + CNT_W;
    localparam logic [N-1:0] FULL = '1;

    logic [CNT_W-1:0]  cnt_q,  cnt_nxt;
    logic [CNT_W-1:0]  thr_q,  thr_nxt;
    logic              full_q, full_nxt;
    logic [PROD_W-1:0] prod;
    logic [CNT_W-1:0]  thr_calc;

    // High-time of a period in counter ticks: (duty * PERIOD) >> N
    assign prod     = PROD_W'(duty) * PROD_W'(PERIOD);
    assign thr_calc = CNT_W'(prod >> N);

    // Period counter and compare latch; the latch opens only on the edge
    // where the counter returns to 0, so a period's width never changes
    always_comb begin
        cnt_nxt  = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
        thr_nxt  = thr_q;
        full_nxt = full_q;
        if (cnt_nxt == '0) begin
            thr_nxt  = thr_calc;
            full_nxt = (duty == FULL);
        end
    end

    // Counter, latched compare and registered output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            thr_q  <= '0;
            full_q <= 1'b0;
            pwm    <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            thr_q  <= thr_nxt;
            full_q <= full_nxt;
            // Full-scale duty is held solidly high instead of dropping the last tick
            pwm    <= full_nxt || (cnt_nxt < thr_nxt);
        end
    end

endmodule

// File: rtl/fan_speed_ramp_ctrl.sv
// Multi-level fan controller: level selection, soft ramp, off-timer and PWM.
module fan_speed_ramp_ctrl
    import fan_pkg::*;
#(
    parameter int SYS_FREQ     = 125,
    parameter int N            = 12,
    parameter int LEVELS       = 7,
    parameter int WRAP         = 0,
    parameter int PWM_FREQ     = 200,
    parameter int RAMP_DIV     = 12500,
    parameter int RAMP_INC     = 64,
    parameter int SEC_DIV      = 125000000,
    parameter int TIMER_UNIT_S = 3600
) (
    input logic                  clk,
    input logic                  reset_n,
    fan_speed_ramp_ctrl_if.slave bus
);

    localparam int RAMP_W = (fan_clog2(RAMP_DIV) < 1) ? 1 : fan_clog2(RAMP_DIV);
    localparam int SEC_W  = (fan_clog2(SEC_DIV) < 1) ? 1 : fan_clog2(SEC_DIV);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(LEVELS);
    localparam logic [N-1:0]       RAMP_STEP = N'(RAMP_INC);

    logic [LEVEL_W-1:0] level_q,        level_nxt;
    timer_sel_e         timer_sel_q,    timer_sel_nxt;
    logic [TIMER_W-1:0] timer_remain_q, timer_remain_nxt;
    logic [SEC_W-1:0]   sec_cnt_q,      sec_cnt_nxt;
    logic [RAMP_W-1:0]  ramp_cnt_q,     ramp_cnt_nxt;
    logic [N-1:0]       duty_q,         duty_nxt;
    logic               ramping_q,      ramping_nxt;
    logic [N-1:0]       target_q,       target_nxt;
    logic               ramp_tick, timer_run, sec_tick, expire;
    logic               pwm_out;

    // Level-to-duty table, evaluated at elaboration
    logic [N-1:0] duty_lut [16];
    for (genvar g = 0; g < 16; g++) begin : g_lut
        assign duty_lut[g] = N'(level_to_duty(g, N, LEVELS));
    end

    assign target_q   = duty_lut[level_q];
    assign target_nxt = duty_lut[level_nxt];

    // Tick strobes: the ramp divider free-runs, the second divider runs only
    // while the fan is on and a timer is pending
    assign ramp_tick = (ramp_cnt_q == RAMP_W'(RAMP_DIV - 1));
    assign timer_run = (level_q != '0) && (timer_remain_q != '0);
    assign sec_tick  = timer_run && (sec_cnt_q == SEC_W'(SEC_DIV - 1));
    assign expire    = sec_tick && (timer_remain_q == TIMER_W'(1)) && (timer_sel_q != T_OFF);

    // Level next-state: enable and timer expiry override the buttons
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can leave it unassigned and infer a latch.
        level_nxt = level_q;
        if (!bus.fan_en || expire) begin
            level_nxt = '0;
        end else if (bus.btn_up_p && !bus.btn_down_p) begin
            if (level_q == LEVEL_MAX) begin
                level_nxt = (WRAP != 0) ? '0 : LEVEL_MAX;
            end else begin
                level_nxt = level_q + 1'b1;
            end
        end else if (bus.btn_down_p && !bus.btn_up_p) begin
            if (level_q == '0) begin
                level_nxt = (WRAP != 0) ? LEVEL_MAX : '0;
            end else begin
                level_nxt = level_q - 1'b1;
            end
        end
    end

    // Timer next-state: a press reloads and restarts the second divider
    always_comb begin
        timer_sel_nxt    = timer_sel_q;
        timer_remain_nxt = timer_remain_q;
        sec_cnt_nxt      = sec_cnt_q;
        if (!bus.fan_en || expire) begin
            timer_sel_nxt    = T_OFF;
            timer_remain_nxt = '0;
            sec_cnt_nxt      = '0;
        end else if (bus.btn_timer_p) begin
            timer_sel_nxt    = timer_sel_e'(timer_sel_q + 2'd1);
            timer_remain_nxt = TIMER_W'(timer_mult(timer_sel_nxt) * TIMER_UNIT_S);
            sec_cnt_nxt      = '0;
        end else if (sec_tick) begin
            timer_remain_nxt = timer_remain_q - 1'b1;
            sec_cnt_nxt      = '0;
        end else if (timer_run) begin
            sec_cnt_nxt      = sec_cnt_q + 1'b1;
        end
    end

    // Ramp engine: step toward the current target, landing exactly on it
    always_comb begin
        ramp_cnt_nxt = ramp_tick ? '0 : ramp_cnt_q + 1'b1;
        duty_nxt     = duty_q;
        if (ramp_tick) begin
            if (duty_q < target_q) begin
                duty_nxt = ((target_q - duty_q) > RAMP_STEP) ? duty_q + RAMP_STEP : target_q;
            end else if (duty_q > target_q) begin
                duty_nxt = ((duty_q - target_q) > RAMP_STEP) ? duty_q - RAMP_STEP : target_q;
            end
        end
        // Compared against the target the level will have after this edge
        ramping_nxt = (duty_nxt != target_nxt);
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q        <= '0;
            timer_sel_q    <= T_OFF;
            timer_remain_q <= '0;
            sec_cnt_q      <= '0;
            ramp_cnt_q     <= '0;
            duty_q         <= '0;
            ramping_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            level_q        <= level_nxt;
            timer_sel_q    <= timer_sel_nxt;
            timer_remain_q <= timer_remain_nxt;
            sec_cnt_q      <= sec_cnt_nxt;
            ramp_cnt_q     <= ramp_cnt_nxt;
            duty_q         <= duty_nxt;
            ramping_q      <= ramping_nxt;
        end
    end

    fan_pwm_gen #(
        .SYS_FREQ (SYS_FREQ),
        .N        (N),
        .PWM_FREQ (PWM_FREQ)
    ) u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .duty    (duty_q),
        .pwm     (pwm_out)
    );

    // Outputs: all driven straight from registers
    always_comb begin
        bus.level        = level_q;
        bus.duty_now     = duty_q;
        bus.ramping      = ramping_q;
        bus.timer_sel    = timer_sel_q;
        bus.timer_remain = timer_remain_q;
        bus.pwm          = pwm_out;
    end

endmodule
